// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and sizes for the mux_scan_ctrl slice.
//  state_t  : sequencer states
//  SET_W    : settle count width (settle input)
//  DWL_W    : dwell counter width (max window 2**15)
//  ACC_EXT  : accumulator headroom; accumulator is RES+ACC_EXT bits
//  acc_w()  : accumulator width for a given data width
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DWELL
  } state_t;

  localparam int unsigned SET_W   = 8;
  localparam int unsigned DWL_W   = 16;
  localparam int unsigned RES_DEF = 14;
  localparam int unsigned ACC_EXT = 15;
  localparam int unsigned ACC_W   = RES_DEF + ACC_EXT;

  function automatic int unsigned acc_w(input int unsigned res);
    return res + ACC_EXT;
  endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch: next enabled channel search.
//  mask : channel enable mask
//  cur  : current channel
//  nxt  : lowest set bit of mask strictly above cur, else lowest set bit
//  wrap : 1 when the search wrapped (no set bit above cur)
module mux_scan_next_ch (
  input  logic [15:0] mask,
  input  logic [3:0]  cur,
  output logic [3:0]  nxt,
  output logic        wrap
);

  logic [3:0] above;
  logic [3:0] lowest;
  logic       found;

  always_comb begin
    above  = '0;
    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (mask[i] && !found && (i > 32'(cur))) begin
        above = 4'(i);
        found = 1'b1;
      end
    end
    for (int unsigned i = 16; i > 0; i--) begin
      if (mask[i-1]) lowest = 4'(i - 1);
    end
    wrap = !found;
    nxt  = found ? above : lowest;
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin sequencer for a 16:1 registered signal muxer.
// Per enabled channel: settle (settle+MUX_LAT cycles), dwell (2**dwell_log2
// samples), then one result cycle carrying dat_vld.
// Optional feature macro: MUX_SCAN_AVG_EN (dat_o = floor average of the dwell
// window); undefined -> dat_o = last dwell sample.
//  clk, rst         : clock, asynchronous active-high reset
//  en, mask         : scan enable level, channel enable mask
//  settle           : extra settle cycles after a sel change
//  dwell_log2       : dwell window exponent
//  dat_i            : muxer output (signed)
//  sel              : muxer select
//  dat_o, dat_ch    : channel result and its index
//  dat_vld          : result strobe
//  scan_done        : strobe with the result of the last channel of a scan
//  busy             : state other than IDLE
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int RES     = 14,
  parameter int MUX_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [15:0]           mask,
  input  logic [7:0]            settle,
  input  logic [3:0]            dwell_log2,
  input  logic signed [RES-1:0] dat_i,
  output logic [3:0]            sel,
  output logic signed [RES-1:0] dat_o,
  output logic [3:0]            dat_ch,
  output logic                  dat_vld,
  output logic                  scan_done,
  output logic                  busy
);

  localparam int unsigned SCNT_W = $clog2(255 + MUX_LAT);

  state_t             state;
  logic [3:0]         ch;
  logic [3:0]         nxt_q;
  logic [SET_W-1:0]   set_q;
  logic [3:0]         dl_q;
  logic [SCNT_W-1:0]  scnt;
  logic [DWL_W-1:0]   dcnt;
  logic               fin;

  logic               start_ok;
  logic [3:0]         cur;
  logic [3:0]         nxt;
  logic               wrap;
  logic               settle_end;
  logic               dwell_end;
  logic               go_settle;
  logic               sample;
  logic signed [RES-1:0] result;

  assign start_ok   = en && (mask != '0);
  // From IDLE, searching above 15 yields the lowest set bit.
  assign cur        = (state == ST_IDLE) ? 4'hF : ch;
  assign settle_end = (scnt == (SCNT_W'(set_q) + SCNT_W'(MUX_LAT - 1)));
  assign dwell_end  = (dcnt == ((DWL_W'(1) << dl_q) - DWL_W'(1)));
  assign go_settle  = start_ok && ((state == ST_IDLE) || ((state == ST_DWELL) && fin));
  assign sample     = (state == ST_DWELL) && !fin;

  mux_scan_next_ch u_next (
    .mask (mask),
    .cur  (cur),
    .nxt  (nxt),
    .wrap (wrap)
  );

`ifdef MUX_SCAN_AVG_EN
  localparam int unsigned AW = acc_w(RES);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] avg;

  assign acc_sum = acc + {{(AW - RES){dat_i[RES-1]}}, dat_i};
  assign avg     = acc_sum >>> dl_q;
  assign result  = RES'(avg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (go_settle) begin
      acc <= '0;
    end else if (sample) begin
      acc <= acc_sum;
    end
  end
`else
  assign result = dat_i;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ch        <= '0;
      nxt_q     <= '0;
      set_q     <= '0;
      dl_q      <= '0;
      scnt      <= '0;
      dcnt      <= '0;
      fin       <= 1'b0;
      sel       <= '0;
      dat_o     <= '0;
      dat_ch    <= '0;
      dat_vld   <= 1'b0;
      scan_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      dat_vld   <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go_settle) begin
            ch    <= nxt;
            sel   <= nxt;
            set_q <= settle;
            dl_q  <= dwell_log2;
            scnt  <= '0;
            busy  <= 1'b1;
            state <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_end) begin
            dcnt  <= '0;
            state <= ST_DWELL;
          end else begin
            scnt <= scnt + SCNT_W'(1);
          end
        end
        ST_DWELL: begin
          // fin marks the result cycle that follows the last dwell sample;
          // it stays in DWELL so the FSM keeps three states.
          if (fin) begin
            fin <= 1'b0;
            if (go_settle) begin
              ch    <= nxt_q;
              sel   <= nxt_q;
              set_q <= settle;
              dl_q  <= dwell_log2;
              scnt  <= '0;
              state <= ST_SETTLE;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else begin
            dcnt <= dcnt + DWL_W'(1);
            if (dwell_end) begin
              fin       <= 1'b1;
              dat_vld   <= 1'b1;
              dat_ch    <= ch;
              dat_o     <= result;
              scan_done <= wrap;
              nxt_q     <= nxt;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
